// File: rtl/dm_port_arbiter.sv
// Shares the single-port synchronous-read data RAM between the MEM load/store port and the
// debug read port: MEM has priority, a streak counter bounds how long debug can be starved.
module dm_port_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_req,
    input  logic [3:0]  mem_wen,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    output logic        mem_ack,
    output logic [31:0] mem_rdata,
    input  logic        dbg_req,
    input  logic [31:0] dbg_addr,
    output logic        dbg_ack,
    output logic [31:0] dbg_rdata,
    output logic [31:0] ram_addr,
    output logic [3:0]  ram_wen,
    output logic [31:0] ram_wdata,
    input  logic [31:0] ram_rdata
);
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RESP_M = 2'd1,
        RESP_D = 2'd2
    } state_t;

    state_t        state, state_next;
    logic [SW-1:0] streak, streak_next;
    logic [31:0]   mem_rdata_q, dbg_rdata_q;
    logic          mem_win, dbg_win;

    // Grants exist only in IDLE; debug overrides MEM once MEM has used up its streak
    always_comb begin
        mem_win = 1'b0;
        dbg_win = 1'b0;
        if (state == IDLE) begin
            dbg_win = dbg_req && (!mem_req || (streak == LIMIT));
            mem_win = mem_req && !dbg_win;
        end
    end

    always_comb begin
        state_next  = state;
        streak_next = streak;
        ram_addr    = mem_addr;
        ram_wen     = 4'b0000;
        mem_ack     = 1'b0;
        dbg_ack     = 1'b0;

        case (state)
            IDLE: begin
                if (dbg_win) begin
                    ram_addr   = dbg_addr;
                    state_next = RESP_D;
                end else if (mem_win) begin
                    ram_wen = mem_wen;
                    if (mem_wen != 4'b0000) begin
                        mem_ack = 1'b1;
                    end else begin
                        state_next = RESP_M;
                    end
                end
            end
            RESP_M: begin
                mem_ack    = 1'b1;
                state_next = IDLE;
            end
            RESP_D: begin
                dbg_ack    = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase

        if (!dbg_req || dbg_win) begin
            streak_next = '0;
        end else if (mem_win && (streak != LIMIT)) begin
            streak_next = streak + SW'(1);
        end

        // Reset kills any ack or write still being presented this cycle
        if (reset) begin
            ram_wen = 4'b0000;
            mem_ack = 1'b0;
            dbg_ack = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            streak      <= '0;
            mem_rdata_q <= '0;
            dbg_rdata_q <= '0;
        end else begin
            state  <= state_next;
            streak <= streak_next;
            if (state == RESP_M) begin
                mem_rdata_q <= ram_rdata;
            end
            if (state == RESP_D) begin
                dbg_rdata_q <= ram_rdata;
            end
        end
    end

    // Read data is forwarded straight from the RAM in the ack cycle, then held
    assign mem_rdata = ((state == RESP_M) && !reset) ? ram_rdata : mem_rdata_q;
    assign dbg_rdata = ((state == RESP_D) && !reset) ? ram_rdata : dbg_rdata_q;
    assign ram_wdata = mem_wdata;

endmodule

// File: tb/tb_dm_port_arbiter.sv
// Bench for dm_port_arbiter: directed vector table, then random traffic against a
// transaction-level model of the arbitration rules and a shadow copy of RAM contents.
module tb_dm_port_arbiter;
    localparam int L = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_req;
    logic [3:0]  mem_wen;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        dbg_req;
    logic [31:0] dbg_addr;
    logic        dbg_ack;
    logic [31:0] dbg_rdata;
    logic [31:0] ram_addr;
    logic [3:0]  ram_wen;
    logic [31:0] ram_wdata, ram_rdata;

    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    dm_port_arbiter #(.STARVE_LIMIT(L)) dut (
        .clk(clk), .reset(reset),
        .mem_req(mem_req), .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .dbg_req(dbg_req), .dbg_addr(dbg_addr), .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata),
        .ram_addr(ram_addr), .ram_wen(ram_wen), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    // Synchronous-read RAM, 256 words, byte-write
    logic [31:0] ram [0:255];
    logic        ram_loaded = 1'b0;

    function automatic logic [31:0] init_word(input int i);
        if (i == 4) return 32'hDEADBEEF;
        if (i == 12) return 32'h12345678;
        return 32'h1000_0000 + 32'(i);
    endfunction

    always @(posedge clk) begin
        if (!ram_loaded) begin
            for (int i = 0; i < 256; i++) ram[i] <= init_word(i);
            ram_loaded <= 1'b1;
        end else begin
            for (int b = 0; b < 4; b++)
                if (ram_wen[b]) ram[ram_addr[9:2]][8*b +: 8] <= ram_wdata[8*b +: 8];
        end
        ram_rdata <= ram[ram_addr[9:2]];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic        rst;
        logic        mreq;
        logic [3:0]  mwen;
        logic [31:0] maddr;
        logic [31:0] mwdata;
        logic        dreq;
        logic [31:0] daddr;
        logic        e_mack;
        logic        e_dack;
        logic [3:0]  e_wen;
        logic        chk_addr;
        logic [31:0] e_addr;
        logic        chk_rd;
        logic [31:0] e_mrd;
        logic [31:0] e_drd;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic rst, input logic mreq, input logic [3:0] mwen,
                       input logic [31:0] maddr, input logic [31:0] mwdata,
                       input logic dreq, input logic [31:0] daddr,
                       input logic e_mack, input logic e_dack, input logic [3:0] e_wen,
                       input logic chk_addr, input logic [31:0] e_addr,
                       input logic chk_rd, input logic [31:0] e_mrd, input logic [31:0] e_drd);
        vq.push_back('{rst, mreq, mwen, maddr, mwdata, dreq, daddr,
                       e_mack, e_dack, e_wen, chk_addr, e_addr, chk_rd, e_mrd, e_drd});
    endtask

    task automatic apply_vec(input vec_t v, input int idx);
        reset     = v.rst;
        mem_req   = v.mreq;
        mem_wen   = v.mwen;
        mem_addr  = v.maddr;
        mem_wdata = v.mwdata;
        dbg_req   = v.dreq;
        dbg_addr  = v.daddr;
        @(negedge clk);
        check($sformatf("v%0d.mem_ack", idx), 32'(mem_ack), 32'(v.e_mack));
        check($sformatf("v%0d.dbg_ack", idx), 32'(dbg_ack), 32'(v.e_dack));
        check($sformatf("v%0d.ram_wen", idx), 32'(ram_wen), 32'(v.e_wen));
        if (v.chk_addr) check($sformatf("v%0d.ram_addr", idx), ram_addr, v.e_addr);
        if (v.chk_rd) begin
            check($sformatf("v%0d.mem_rdata", idx), mem_rdata, v.e_mrd);
            check($sformatf("v%0d.dbg_rdata", idx), dbg_rdata, v.e_drd);
        end
        @(posedge clk);
        #1;
    endtask

    // Reference model state
    logic [31:0] gold [0:255];
    int          ph;          // 0 free, 1 MEM read outstanding, 2 debug read outstanding
    logic [7:0]  pend;
    int          mem_run;     // MEM grants handed out since debug started waiting
    logic [31:0] held_m, held_d;
    logic        m_act, d_act;

    initial begin
        reset = 1'b1; mem_req = 1'b0; mem_wen = 4'h0; mem_addr = '0; mem_wdata = '0;
        dbg_req = 1'b0; dbg_addr = '0;
        repeat (3) @(posedge clk);
        #1;

        // rst mreq wen maddr wdata dreq daddr | mack dack wen chka addr chkrd mrd drd
        add(1, 0, 4'h0, 32'h00, 32'h0, 0, 32'h30, 0, 0, 4'h0, 0, 32'h00, 1, 32'h0, 32'h0);
        // single load at 0x10
        add(0, 1, 4'h0, 32'h10, 32'h0, 0, 32'h30, 0, 0, 4'h0, 1, 32'h10, 1, 32'h0, 32'h0);
        add(0, 1, 4'h0, 32'h10, 32'h0, 0, 32'h30, 1, 0, 4'h0, 0, 32'h00, 1, 32'hDEADBEEF, 32'h0);
        add(0, 0, 4'h0, 32'h00, 32'h0, 0, 32'h30, 0, 0, 4'h0, 0, 32'h00, 1, 32'hDEADBEEF, 32'h0);
        // three back-to-back stores, lane 1
        add(0, 1, 4'h2, 32'h20, 32'h11111111, 0, 32'h30, 1, 0, 4'h2, 1, 32'h20, 1, 32'hDEADBEEF, 32'h0);
        add(0, 1, 4'h2, 32'h24, 32'h11111111, 0, 32'h30, 1, 0, 4'h2, 1, 32'h24, 1, 32'hDEADBEEF, 32'h0);
        add(0, 1, 4'h2, 32'h28, 32'h11111111, 0, 32'h30, 1, 0, 4'h2, 1, 32'h28, 1, 32'hDEADBEEF, 32'h0);
        add(0, 0, 4'h0, 32'h00, 32'h0, 0, 32'h30, 0, 0, 4'h0, 0, 32'h00, 1, 32'hDEADBEEF, 32'h0);
        // load and debug together: MEM first, debug two cycles later
        add(0, 1, 4'h0, 32'h10, 32'h0, 1, 32'h30, 0, 0, 4'h0, 1, 32'h10, 1, 32'hDEADBEEF, 32'h0);
        add(0, 1, 4'h0, 32'h10, 32'h0, 1, 32'h30, 1, 0, 4'h0, 0, 32'h00, 1, 32'hDEADBEEF, 32'h0);
        add(0, 0, 4'h0, 32'h10, 32'h0, 1, 32'h30, 0, 0, 4'h0, 1, 32'h30, 1, 32'hDEADBEEF, 32'h0);
        add(0, 0, 4'h0, 32'h10, 32'h0, 1, 32'h30, 0, 1, 4'h0, 0, 32'h00, 1, 32'hDEADBEEF, 32'h12345678);
        add(0, 0, 4'h0, 32'h00, 32'h0, 0, 32'h30, 0, 0, 4'h0, 0, 32'h00, 1, 32'hDEADBEEF, 32'h12345678);
        // MEM reads leave dbg_rdata alone; second read sees the earlier lane-1 store
        add(0, 1, 4'h0, 32'h14, 32'h0, 0, 32'h30, 0, 0, 4'h0, 1, 32'h14, 1, 32'hDEADBEEF, 32'h12345678);
        add(0, 1, 4'h0, 32'h14, 32'h0, 0, 32'h30, 1, 0, 4'h0, 0, 32'h00, 1, 32'h10000005, 32'h12345678);
        add(0, 1, 4'h0, 32'h20, 32'h0, 0, 32'h30, 0, 0, 4'h0, 1, 32'h20, 1, 32'h10000005, 32'h12345678);
        add(0, 1, 4'h0, 32'h20, 32'h0, 0, 32'h30, 1, 0, 4'h0, 0, 32'h00, 1, 32'h10001108, 32'h12345678);
        add(0, 0, 4'h0, 32'h00, 32'h0, 0, 32'h30, 0, 0, 4'h0, 0, 32'h00, 1, 32'h10001108, 32'h12345678);

        // Starvation: L stores, then debug; debug grant clears the streak so L more stores follow
        for (int i = 0; i < L; i++)
            add(0, 1, 4'hF, 32'h80 + 32'(4*i), 32'hCAFEF00D, 1, 32'h30, 1, 0, 4'hF, 1,
                32'h80 + 32'(4*i), 1, 32'h10001108, 32'h12345678);
        add(0, 1, 4'hF, 32'h90, 32'hCAFEF00D, 1, 32'h30, 0, 0, 4'h0, 1, 32'h30, 1, 32'h10001108, 32'h12345678);
        add(0, 1, 4'hF, 32'h90, 32'hCAFEF00D, 1, 32'h30, 0, 1, 4'h0, 0, 32'h00, 1, 32'h10001108, 32'h12345678);
        for (int i = 0; i < L; i++)
            add(0, 1, 4'hF, 32'h90 + 32'(4*i), 32'hCAFEF00D, 1, 32'h30, 1, 0, 4'hF, 1,
                32'h90 + 32'(4*i), 1, 32'h10001108, 32'h12345678);
        add(0, 1, 4'hF, 32'hA0, 32'hCAFEF00D, 1, 32'h30, 0, 0, 4'h0, 1, 32'h30, 1, 32'h10001108, 32'h12345678);
        add(0, 1, 4'hF, 32'hA0, 32'hCAFEF00D, 1, 32'h30, 0, 1, 4'h0, 0, 32'h00, 1, 32'h10001108, 32'h12345678);
        add(0, 1, 4'hF, 32'hA0, 32'hCAFEF00D, 0, 32'h30, 1, 0, 4'hF, 1, 32'hA0, 1, 32'h10001108, 32'h12345678);
        add(0, 0, 4'h0, 32'h00, 32'h0, 0, 32'h30, 0, 0, 4'h0, 0, 32'h00, 1, 32'h10001108, 32'h12345678);

        // Reset while a load is returning: ack suppressed, held request re-issues afterwards
        add(0, 1, 4'h0, 32'h40, 32'h0, 0, 32'h30, 0, 0, 4'h0, 1, 32'h40, 1, 32'h10001108, 32'h12345678);
        add(1, 1, 4'h0, 32'h40, 32'h0, 0, 32'h30, 0, 0, 4'h0, 0, 32'h00, 0, 32'h0, 32'h0);
        add(0, 1, 4'h0, 32'h40, 32'h0, 0, 32'h30, 0, 0, 4'h0, 1, 32'h40, 1, 32'h0, 32'h0);
        add(0, 1, 4'h0, 32'h40, 32'h0, 0, 32'h30, 1, 0, 4'h0, 0, 32'h00, 1, 32'h10000010, 32'h0);
        add(0, 0, 4'h0, 32'h00, 32'h0, 0, 32'h30, 0, 0, 4'h0, 0, 32'h00, 1, 32'h10000010, 32'h0);

        foreach (vq[i]) apply_vec(vq[i], i);

        // Random traffic against the model
        for (int i = 0; i < 256; i++) gold[i] = ram[i];
        ph = 0; pend = '0; mem_run = 0; held_m = 32'h10000010; held_d = 32'h0;
        m_act = 1'b0; d_act = 1'b0;

        for (int c = 0; c < 3000; c++) begin
            logic        e_mack, e_dack, chk_a, wr;
            logic [3:0]  e_wen;
            logic [31:0] e_addr, e_mrd, e_drd, n_held_m, n_held_d;
            int          n_ph, n_run;
            logic [7:0]  n_pend;

            reset = ($urandom_range(0, 79) == 0);
            if (!m_act && ($urandom_range(0, 1) == 1)) begin
                m_act     = 1'b1;
                mem_wen   = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'h0;
                mem_addr  = {22'b0, 8'($urandom), 2'b00};
                mem_wdata = $urandom;
            end else if (!m_act) begin
                mem_wen   = 4'($urandom);
                mem_addr  = $urandom;
                mem_wdata = $urandom;
            end
            mem_req = m_act;
            if (!d_act && ($urandom_range(0, 2) == 0)) begin
                d_act    = 1'b1;
                dbg_addr = {22'b0, 8'($urandom), 2'b00};
            end else if (!d_act) begin
                dbg_addr = $urandom;
            end
            dbg_req = d_act;

            @(negedge clk);
            e_mack = 1'b0; e_dack = 1'b0; e_wen = 4'h0; chk_a = 1'b0; e_addr = '0; wr = 1'b0;
            n_ph = ph; n_run = mem_run; n_pend = pend; n_held_m = held_m; n_held_d = held_d;
            e_mrd = (ph == 1 && !reset) ? gold[pend] : held_m;
            e_drd = (ph == 2 && !reset) ? gold[pend] : held_d;
            if (reset) begin
                n_ph = 0; n_run = 0; n_held_m = '0; n_held_d = '0;
            end else begin
                if (ph == 1) begin
                    e_mack = 1'b1; n_held_m = gold[pend]; n_ph = 0;
                end else if (ph == 2) begin
                    e_dack = 1'b1; n_held_d = gold[pend]; n_ph = 0;
                end else if (dbg_req && (!mem_req || mem_run >= L)) begin
                    chk_a = 1'b1; e_addr = dbg_addr; n_ph = 2; n_pend = dbg_addr[9:2]; n_run = 0;
                end else if (mem_req) begin
                    chk_a = 1'b1; e_addr = mem_addr; e_wen = mem_wen;
                    if (mem_wen != 4'h0) begin
                        e_mack = 1'b1; wr = 1'b1;
                    end else begin
                        n_ph = 2 - 1; n_pend = mem_addr[9:2];
                    end
                    if (dbg_req) n_run = (mem_run + 1 > L) ? L : mem_run + 1;
                end
                if (!dbg_req) n_run = 0;
            end
            check("rnd.mem_ack", 32'(mem_ack), 32'(e_mack));
            check("rnd.dbg_ack", 32'(dbg_ack), 32'(e_dack));
            check("rnd.ram_wen", 32'(ram_wen), 32'(e_wen));
            check("rnd.ram_wdata", ram_wdata, mem_wdata);
            check("rnd.mem_rdata", mem_rdata, e_mrd);
            check("rnd.dbg_rdata", dbg_rdata, e_drd);
            if (chk_a) check("rnd.ram_addr", ram_addr, e_addr);

            @(posedge clk);
            if (wr)
                for (int b = 0; b < 4; b++)
                    if (mem_wen[b]) gold[mem_addr[9:2]][8*b +: 8] = mem_wdata[8*b +: 8];
            ph = n_ph; pend = n_pend; mem_run = n_run; held_m = n_held_m; held_d = n_held_d;
            #1;
            if (e_mack) m_act = 1'b0;
            if (e_dack) d_act = 1'b0;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
